vga_fb_ctrl: RTL

Bus-mapped write controller for the VGA frame buffer. It is the parametrised successor to the fixed-size pixel-write peripheral. It decodes a 10-register window on the 8-bit processor bus and drives the frame buffer's A-side write port and the signal generator's colour configuration. Beyond single-pixel writes, it adds:
- X auto-increment with row wrap;
- a hardware rectangle-fill engine;
- readable status with a sticky dropped-write flag.

---
 rtl/vga_fb_ctrl_if.sv | 20 ++
 rtl/vga_fb_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_ctrl_if.sv
// Processor bus bundle for the VGA frame-buffer write controller.
// The master drives address, data and strobes; the slave returns registered read data.
interface vga_fb_ctrl_if;
    logic [7:0] BUS_ADDR;
    logic [7:0] BUS_DATA;
    logic       BUS_WE;
    logic       BUS_RE;
    logic [7:0] BUS_DATA_OUT;
    logic       BUS_DATA_OE;

    modport master (
        output BUS_ADDR, BUS_DATA, BUS_WE, BUS_RE,
        input  BUS_DATA_OUT, BUS_DATA_OE
    );

    modport slave (
        input  BUS_ADDR, BUS_DATA, BUS_WE, BUS_RE,
        output BUS_DATA_OUT, BUS_DATA_OE
    );
endinterface

// File: rtl/vga_fb_ctrl.sv
// Bus-mapped frame-buffer write controller: pixel writes with auto-increment,
// rectangle-fill engine, colour config and sticky dropped-write status.
module vga_fb_ctrl #(
    parameter logic [7:0] BASE_ADDR = 8'hB0,
    parameter int         X_W       = 8,
    parameter int         Y_W       = 7,
    parameter int         X_MAX     = 159,
    parameter int         Y_MAX     = 119,
    parameter int         PIX_W     = 1,
    parameter logic [7:0] BG_RESET  = 8'h33,
    parameter logic [7:0] FG_RESET  = 8'hCC
) (
    input  logic                 CLK,
    input  logic                 RESET,
    vga_fb_ctrl_if.slave         bus,
    output logic [X_W+Y_W-1:0]   FB_ADDR,
    output logic [PIX_W-1:0]     FB_DATA,
    output logic                 FB_WE,
    output logic [15:0]          CONFIG_COL,
    output logic                 BUSY
);
    typedef enum logic {IDLE, FILL} state_t;

    state_t           state_q, state_d;
    logic [8:0]       off9;
    logic [3:0]       off;
    logic             hit, wr, rd, wr_pix, wr_cmd;
    logic [X_W-1:0]   x_q, x0_q, fx;
    logic [Y_W-1:0]   y_q, y0_q, fy;
    logic [1:0]       ctrl_q;
    logic [7:0]       fw_q, fh_q, w_q, h_q;
    logic [7:0]       cx_q, cy_q, cx_d, cy_d;
    logic [7:0]       rdata;
    logic [PIX_W-1:0] fv_q, v_q;
    logic             dropped_q, start, adv, drop;

    // Ninth bit catches addresses below the window.
    assign off9   = {1'b0, bus.BUS_ADDR} - {1'b0, BASE_ADDR};
    assign hit    = !off9[8] && (off9[7:0] < 8'd10);
    assign off    = off9[3:0];
    assign wr     = bus.BUS_WE && hit;
    assign rd     = bus.BUS_RE && hit;
    assign wr_pix = wr && (off == 4'd2);
    assign wr_cmd = wr && (off == 4'd9);
    assign BUSY   = (state_q == FILL);

    // cx/cy index the pixel currently on the FB port.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        adv     = 1'b0;
        drop    = 1'b0;
        cx_d    = 8'd0;
        cy_d    = 8'd0;
        unique case (state_q)
            IDLE: begin
                if (wr_cmd && fw_q != 8'd0 && fh_q != 8'd0) begin
                    state_d = FILL;
                    start   = 1'b1;
                end
            end
            FILL: begin
                drop = wr_pix || wr_cmd;
                if (cx_q == w_q - 8'd1) begin
                    if (cy_q == h_q - 8'd1) begin
                        state_d = IDLE;
                    end else begin
                        adv  = 1'b1;
                        cy_d = cy_q + 8'd1;
                    end
                end else begin
                    adv  = 1'b1;
                    cx_d = cx_q + 8'd1;
                    cy_d = cy_q;
                end
            end
        endcase
    end

    assign fx = x0_q + X_W'(cx_d);
    assign fy = y0_q + Y_W'(cy_d);

    always_comb begin
        rdata = 8'd0;
        case (off)
            4'd0:    rdata = 8'(x_q);
            4'd1:    rdata = 8'(y_q);
            4'd3:    rdata = CONFIG_COL[15:8];
            4'd4:    rdata = CONFIG_COL[7:0];
            4'd5:    rdata = {6'd0, ctrl_q};
            4'd6:    rdata = fw_q;
            4'd7:    rdata = fh_q;
            4'd8:    rdata = 8'(fv_q);
            4'd9:    rdata = {6'd0, dropped_q, BUSY};
            default: rdata = 8'd0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            x_q              <= '0;
            y_q              <= '0;
            x0_q             <= '0;
            y0_q             <= '0;
            ctrl_q           <= 2'd0;
            fw_q             <= 8'd0;
            fh_q             <= 8'd0;
            w_q              <= 8'd0;
            h_q              <= 8'd0;
            cx_q             <= 8'd0;
            cy_q             <= 8'd0;
            fv_q             <= '0;
            v_q              <= '0;
            dropped_q        <= 1'b0;
            CONFIG_COL       <= {BG_RESET, FG_RESET};
            FB_ADDR          <= '0;
            FB_DATA          <= '0;
            FB_WE            <= 1'b0;
            bus.BUS_DATA_OUT <= 8'd0;
            bus.BUS_DATA_OE  <= 1'b0;
        end else begin
            FB_WE           <= 1'b0;
            bus.BUS_DATA_OE <= rd;
            if (rd) bus.BUS_DATA_OUT <= rdata;

            if (wr) begin
                case (off)
                    4'd0:    x_q              <= bus.BUS_DATA[X_W-1:0];
                    4'd1:    y_q              <= bus.BUS_DATA[Y_W-1:0];
                    4'd3:    CONFIG_COL[15:8] <= bus.BUS_DATA;
                    4'd4:    CONFIG_COL[7:0]  <= bus.BUS_DATA;
                    4'd5:    ctrl_q           <= bus.BUS_DATA[1:0];
                    4'd6:    fw_q             <= bus.BUS_DATA;
                    4'd7:    fh_q             <= bus.BUS_DATA;
                    4'd8:    fv_q             <= bus.BUS_DATA[PIX_W-1:0];
                    default: ;
                endcase
            end

            if (wr_pix && state_q == IDLE) begin
                FB_WE   <= 1'b1;
                FB_ADDR <= {y_q, x_q};
                FB_DATA <= bus.BUS_DATA[PIX_W-1:0];
                if (ctrl_q[0]) begin
                    if (x_q == X_W'(X_MAX)) begin
                        x_q <= '0;
                        if (ctrl_q[1])
                            y_q <= (y_q == Y_W'(Y_MAX)) ? '0 : y_q + Y_W'(1);
                    end else begin
                        x_q <= x_q + X_W'(1);
                    end
                end
            end

            if (start) begin
                x0_q    <= x_q;
                y0_q    <= y_q;
                w_q     <= fw_q;
                h_q     <= fh_q;
                v_q     <= fv_q;
                cx_q    <= 8'd0;
                cy_q    <= 8'd0;
                FB_WE   <= 1'b1;
                FB_ADDR <= {y_q, x_q};
                FB_DATA <= fv_q;
            end else if (adv) begin
                cx_q    <= cx_d;
                cy_q    <= cy_d;
                FB_WE   <= 1'b1;
                FB_ADDR <= {fy, fx};
                FB_DATA <= v_q;
            end

            // A drop in the same cycle as a status read keeps the flag set.
            if (drop)
                dropped_q <= 1'b1;
            else if (rd && off == 4'd9)
                dropped_q <= 1'b0;
        end
    end
endmodule
